// File: rtl/monolith_pkg.sv
// rtl/monolith_pkg.sv - shared types and defaults for the Monolith chunk scheduler
package monolith_pkg;

  localparam int DEF_CHUNK_SIZE = 16;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT1 = 3'd2,
    LATCH = 3'd3,
    START = 3'd4,
    RUN   = 3'd5,
    OUT   = 3'd6
  } sched_state_e;

  typedef logic [DEF_DATA_WIDTH-1:0] chunk_t [DEF_CHUNK_SIZE];

endpackage

// File: rtl/monolith_watchdog.sv
// rtl/monolith_watchdog.sv - cycle watchdog that expires on the TIMEOUT_CYCLES-th enabled cycle
module monolith_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Counter starts at 0 on the first enabled cycle, so expiry lands on cycle TIMEOUT_CYCLES.
  assign expire = enable && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/monolith_stream_sched.sv
// rtl/monolith_stream_sched.sv - fetches chunks from the sink FIFO, runs the Monolith core, emits framed results
module monolith_stream_sched
  import monolith_pkg::*;
#(
  parameter int CHUNK_SIZE     = DEF_CHUNK_SIZE,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             S_AXIS_ACLK,
  input  logic                             S_AXIS_ARESETN,
  input  logic                             enable,
  input  logic [CNT_WIDTH-1:0]             cfg_chunks_per_pkt,
  input  logic                             err_clear,
  input  logic                             fifo_empty,
  output logic                             fifo_read_strobe,
  input  logic [CHUNK_SIZE*DATA_WIDTH-1:0] fifo_out,
  output logic                             core_start,
  output logic [CHUNK_SIZE*DATA_WIDTH-1:0] core_in,
  input  logic                             core_done,
  input  logic [CHUNK_SIZE*DATA_WIDTH-1:0] core_result,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHUNK_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                             out_last,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             chunks_done,
  output logic                             err_timeout
);

  sched_state_e         state;
  logic [CNT_WIDTH-1:0] pkt_cfg;
  logic [CNT_WIDTH-1:0] pkt_idx;
  logic [CNT_WIDTH-1:0] cfg_eff;
  logic                 wd_expire;

  assign cfg_eff = (cfg_chunks_per_pkt == '0) ? CNT_WIDTH'(1) : cfg_chunks_per_pkt;
  assign busy    = (state != IDLE);

  monolith_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (S_AXIS_ACLK),
    .rst_n (S_AXIS_ARESETN),
    .clear (state != RUN),
    .enable(state == RUN),
    .expire(wd_expire)
  );

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state            <= IDLE;
      fifo_read_strobe <= 1'b0;
      core_start       <= 1'b0;
      core_in          <= '0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_last         <= 1'b0;
      chunks_done      <= '0;
      err_timeout      <= 1'b0;
      pkt_cfg          <= '0;
      pkt_idx          <= '0;
    end else begin
      // A watchdog expiry later in this block overrides a same-cycle clear.
      if (err_clear) begin
        err_timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (enable && !fifo_empty) begin
            fifo_read_strobe <= 1'b1;
            state            <= FETCH;
            if (pkt_idx == '0) begin
              pkt_cfg <= cfg_eff;
            end
          end
        end
        FETCH: begin
          fifo_read_strobe <= 1'b0;
          state            <= WAIT1;
        end
        WAIT1: begin
          state <= LATCH;
        end
        LATCH: begin
          core_in    <= fifo_out;
          core_start <= 1'b1;
          state      <= START;
        end
        START: begin
          core_start <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          if (core_done) begin
            out_data  <= core_result;
            out_valid <= 1'b1;
            out_last  <= (pkt_idx == pkt_cfg - CNT_WIDTH'(1));
            state     <= OUT;
          end else if (wd_expire) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            chunks_done <= chunks_done + CNT_WIDTH'(1);
            pkt_idx     <= out_last ? '0 : pkt_idx + CNT_WIDTH'(1);
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_monolith_stream_sched.sv
// tb/tb_monolith_stream_sched.sv - directed and randomized bench for monolith_stream_sched
module tb_monolith_stream_sched;
  import monolith_pkg::*;

  localparam int CS = DEF_CHUNK_SIZE;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int CW = 16;
  localparam int TO = 16;
  localparam int W  = CS * DW;
  typedef logic [W-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          err_clear = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          core_done = 1'b0;
  logic          out_ready = 1'b1;
  logic [CW-1:0] cfg = 16'd1;
  vec_t          fifo_out = '0;
  vec_t          core_result = '0;
  logic          fifo_read_strobe, core_start, out_valid, out_last, busy, err_timeout;
  vec_t          core_in, out_data;
  logic [CW-1:0] chunks_done;

  always #5 clk = ~clk;

  monolith_stream_sched #(
    .CHUNK_SIZE(CS), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .enable(enable),
    .cfg_chunks_per_pkt(cfg), .err_clear(err_clear), .fifo_empty(fifo_empty),
    .fifo_read_strobe(fifo_read_strobe), .fifo_out(fifo_out), .core_start(core_start),
    .core_in(core_in), .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .chunks_done(chunks_done), .err_timeout(err_timeout)
  );

  int            checks = 0;
  int            failures = 0;
  vec_t          fifo_q[$];
  int            cyc = 0;
  int            strobe_cyc = -100;
  int            strobes = 0;
  int            pushed = 0;
  int            hs_cnt = 0;
  int            cd = 0;
  int            lat = 5;
  bit            hang = 0;
  bit            model_done = 0;
  vec_t          popped = '0;
  vec_t          exp_res = '0;
  int            m_pos = 0;
  int            m_len = 1;
  int            m_done = 0;
  logic [CW-1:0] cfg_last = 16'd1;
  logic [15:0]   last_pat = '0;

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t plus1(input vec_t c);
    vec_t r;
    for (int i = 0; i < CS; i++) r[i*DW +: DW] = c[i*DW +: DW] + 32'd1;
    return r;
  endfunction

  function automatic vec_t make_chunk(input logic [DW-1:0] base);
    vec_t r;
    for (int i = 0; i < CS; i++) r[i*DW +: DW] = base + DW'(i);
    return r;
  endfunction

  function automatic vec_t rand_chunk();
    vec_t r;
    for (int i = 0; i < CS; i++) r[i*DW +: DW] = $urandom();
    return r;
  endfunction

  task automatic push_chunk(input vec_t c);
    fifo_q.push_back(c);
    pushed++;
    fifo_empty = 1'b0;
  endtask

  // One clock: sample pre-edge outputs, advance, then update FIFO/core/sink models.
  task automatic tick();
    logic p_strobe, p_start, p_done, p_valid, p_ready, p_last;
    vec_t p_core_in, p_data;
    logic [CW-1:0] p_cfg;
    int c;
    p_strobe = fifo_read_strobe; p_start = core_start; p_done = model_done;
    p_valid = out_valid; p_ready = out_ready; p_last = out_last;
    p_core_in = core_in; p_data = out_data; p_cfg = cfg; c = cyc;
    @(posedge clk); #1;
    cyc++;
    if (p_strobe) begin
      strobes++;
      strobe_cyc = c;
      check("strobe_has_chunk", W'(fifo_q.size() != 0), W'(1));
      if (fifo_q.size() != 0) begin
        popped = fifo_q.pop_front();
        fifo_out = popped;
        exp_res = plus1(popped);
        if (m_pos == 0) m_len = (cfg_last == '0) ? 1 : int'(cfg_last);
      end
      fifo_empty = (fifo_q.size() == 0);
    end
    if (p_start) begin
      check("start_latency", W'(c - strobe_cyc), W'(3));
      check("core_in_at_start", p_core_in, popped);
    end
    core_done = 1'b0;
    model_done = 0;
    if (p_start && !hang) cd = lat;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        core_done = 1'b1;
        model_done = 1;
        core_result = plus1(core_in);
      end
    end
    if (p_done) check("valid_after_done", W'(out_valid), W'(1));
    if (p_valid && p_ready) begin
      hs_cnt++;
      check("out_data", p_data, exp_res);
      check("out_last", W'(p_last), W'(m_pos == m_len - 1));
      last_pat = {last_pat[14:0], p_last};
      m_pos = (m_pos == m_len - 1) ? 0 : m_pos + 1;
      m_done++;
      check("chunks_done", W'(chunks_done), W'(CW'(m_done)));
    end
    cfg_last = p_cfg;
  endtask

  task automatic run_hs(input int n, input int budget);
    int target;
    target = hs_cnt + n;
    for (int i = 0; i < budget && hs_cnt < target; i++) tick();
    check("handshake_count", W'(hs_cnt), W'(target));
  endtask

  task automatic wait_start();
    for (int i = 0; i < 50 && !core_start; i++) tick();
    check("core_start_seen", W'(core_start), W'(1));
  endtask

  task automatic check_all_zero();
    check("rst_strobe", W'(fifo_read_strobe), '0);
    check("rst_core_start", W'(core_start), '0);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_last", W'(out_last), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_chunks_done", W'(chunks_done), '0);
    check("rst_err", W'(err_timeout), '0);
    check("rst_core_in", core_in, '0);
    check("rst_out_data", out_data, '0);
  endtask

  initial begin
    vec_t held;
    int   s0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    rst_n = 1'b1;

    // Single chunk, one-chunk packets
    cfg = 16'd1; lat = 5; enable = 1'b1; out_ready = 1'b1;
    push_chunk(make_chunk(32'h100));
    tick();
    check("strobe_after_nonempty", W'(fifo_read_strobe), W'(1));
    run_hs(1, 100);
    check("single_strobe", W'(strobes), W'(1));
    check("t1_core_in", core_in, make_chunk(32'h100));
    check("t1_out_data", out_data, make_chunk(32'h101));
    check("t1_last", W'(last_pat[0]), W'(1));
    check("t1_chunks_done", W'(chunks_done), W'(1));

    // Three-chunk packets over six chunks
    cfg = 16'd3;
    last_pat = '0;
    for (int i = 0; i < 6; i++) push_chunk(rand_chunk());
    run_hs(6, 600);
    check("t2_last_pattern", W'(last_pat[5:0]), W'(6'b001001));
    check("t2_chunks_done", W'(chunks_done), W'(7));

    // Backpressure holds the result and blocks further fetches
    cfg = 16'd1; out_ready = 1'b0;
    push_chunk(rand_chunk());
    push_chunk(rand_chunk());
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    check("t3_valid_seen", W'(out_valid), W'(1));
    held = out_data;
    s0 = strobes;
    repeat (10) begin
      tick();
      check("t3_valid_held", W'(out_valid), W'(1));
      check("t3_data_held", out_data, held);
    end
    check("t3_no_strobe", W'(strobes), W'(s0));
    out_ready = 1'b1;
    run_hs(2, 200);

    // Watchdog: core never finishes
    hang = 1;
    push_chunk(rand_chunk());
    wait_start();
    tick();
    repeat (TO - 1) tick();
    check("t4_err_before", W'(err_timeout), '0);
    check("t4_busy_before", W'(busy), W'(1));
    tick();
    check("t4_err_set", W'(err_timeout), W'(1));
    check("t4_idle", W'(busy), '0);
    check("t4_chunks_kept", W'(chunks_done), W'(CW'(m_done)));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t4_err_cleared", W'(err_timeout), '0);
    hang = 0;
    push_chunk(rand_chunk());
    run_hs(1, 100);

    // Dropping enable mid-chunk lets it finish, then stalls
    cfg = 16'd2;
    for (int i = 0; i < 3; i++) push_chunk(rand_chunk());
    wait_start();
    enable = 1'b0;
    s0 = strobes;
    run_hs(1, 100);
    repeat (20) tick();
    check("t5_no_strobe", W'(strobes), W'(s0));
    check("t5_idle", W'(busy), '0);
    enable = 1'b1;
    run_hs(2, 200);

    // Randomized traffic
    for (int i = 0; i < 30; i++) push_chunk(rand_chunk());
    s0 = hs_cnt + 30;
    for (int i = 0; i < 4000 && hs_cnt < s0; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      enable = ($urandom_range(0, 9) != 0);
      lat = $urandom_range(1, 8);
      if ($urandom_range(0, 15) == 0) cfg = CW'($urandom_range(0, 4));
      tick();
    end
    check("rand_handshakes", W'(hs_cnt), W'(s0));
    enable = 1'b1; out_ready = 1'b1;
    check("strobes_per_chunk", W'(strobes), W'(pushed - fifo_q.size()));

    // Asynchronous reset during RUN
    lat = 8;
    push_chunk(rand_chunk());
    wait_start();
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check_all_zero();
    fifo_q.delete(); fifo_empty = 1'b1; core_done = 1'b0; cd = 0; model_done = 0;
    m_pos = 0; m_done = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s0 = strobes;
    repeat (5) tick();
    check("t7_idle_no_strobe", W'(strobes), W'(s0));
    core_done = 1'b1;
    core_result = rand_chunk();
    tick();
    check("t7_late_done_ignored", W'(out_valid), '0);
    check("t7_still_idle", W'(busy), '0);
    push_chunk(make_chunk(32'h200));
    tick();
    check("t7_strobe_resumes", W'(fifo_read_strobe), W'(1));
    run_hs(1, 100);
    check("t7_chunks_done", W'(chunks_done), W'(1));
    check("t7_out_data", out_data, make_chunk(32'h201));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
